// File: rtl/bcd_to_bin_serial.sv
// bcd_to_bin_serial
//   Serial packed-BCD to binary converter (reverse double dabble). One bit
//   is shifted out of the BCD field into the binary field per clock. After
//   each shift, every BCD digit that is 8 or more has 3 subtracted from it.
//   Latency is fixed at BIN_W cycles from the accepting edge to done.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, sampled only while idle
//   bcd_in   in   4*DIGITS packed BCD, digit 0 in [3:0]
//   busy     out  conversion in progress
//   done     out  one-cycle pulse, bin_out/err valid
//   bin_out  out  converted value, held until the next done
//   err      out  invalid digit seen (valid with done)
//
// Build option
//   BCD2BIN_CHECK_EN : screen bcd_in for digits > 9 on the accepting edge.
//                      An invalid word finishes one cycle later with err=1
//                      and bin_out=0. Without the macro, err is tied low and
//                      invalid digits run through the normal algorithm.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; done may be high for its single cycle
// ST_SHIFT | shifting/correcting; cnt counts the remaining shifts
// ST_ERR   | (check build only) invalid input, report err on the next edge

module bcd_to_bin_serial #(
    parameter int DIGITS = 11,
    parameter int BIN_W  = 37
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef BCD2BIN_CHECK_EN
    localparam logic [1:0] ST_ERR   = 2'd2;
`endif

    logic [1:0]             state_q,   state_d;
    logic [BCD_W-1:0]       bcd_q,     bcd_d;
    logic [BIN_W-1:0]       bin_q,     bin_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [BIN_W-1:0]       bin_out_q, bin_out_d;

    logic [BCD_W+BIN_W-1:0] work_sh;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BCD_W-1:0]       bcd_fix;
    logic [BIN_W-1:0]       bin_shift;

    // Whole work register shifts right as one; a zero enters the BCD MSB.
    assign work_sh   = {bcd_q, bin_q} >> 1;
    assign bcd_shift = work_sh[BCD_W+BIN_W-1:BIN_W];
    assign bin_shift = work_sh[BIN_W-1:0];

`ifdef BCD2BIN_CHECK_EN
    logic [DIGITS-1:0] dig_bad;
    logic              in_bad;
    logic              err_q, err_d;
`endif

    // Per-digit correction applies to the shifted value. Each digit is
    // handled in 4 bits, with no borrow between digits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        logic [3:0] d_sh;
        assign d_sh = bcd_shift[4*gi +: 4];
        assign bcd_fix[4*gi +: 4] = (d_sh >= 4'd8) ? (d_sh - 4'd3) : d_sh;
`ifdef BCD2BIN_CHECK_EN
        assign dig_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
`endif
    end

`ifdef BCD2BIN_CHECK_EN
    assign in_bad = |dig_bad;
`endif

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_out_d = bin_out_q;
`ifdef BCD2BIN_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = CNT_LOAD;
`ifdef BCD2BIN_CHECK_EN
                    if (in_bad) begin
                        state_d = ST_ERR;
                        bcd_d   = '0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_fix;
                bin_d = bin_shift;
                cnt_d = cnt_q - CNT_ONE;
                // Last shift: bin_shift already holds the complete value.
                if (cnt_q == CNT_ONE) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bin_out_d = bin_shift;
`ifdef BCD2BIN_CHECK_EN
                    err_d     = 1'b0;
`endif
                end
            end
`ifdef BCD2BIN_CHECK_EN
            ST_ERR: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                bin_out_d = '0;
                err_d     = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
        end
    end

`ifdef BCD2BIN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
module tb_bcd_to_bin_serial;

    localparam int DIGITS = 11;
    localparam int BIN_W  = 37;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [43:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [36:0]       bin_out;
    logic              err;

    int total = 0;
    int bad   = 0;

    bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [43:0] bcd;
        logic [36:0] exp_bin;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the decimal value the digits denote, by plain arithmetic.
    function automatic logic [36:0] model_bin(input logic [43:0] b);
        longint v = 0;
        logic [3:0] d;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            v = v * 10 + longint'(d);
        end
        return 37'(v);
    endfunction

    function automatic logic [43:0] rand_bcd();
        logic [43:0] b = '0;
        for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Start one conversion and follow it to done.
    task automatic run_conv(input string nm, input logic [43:0] bcd, input logic [36:0] eb,
                            input logic ee, input int lat, input bit chk_bin);
        int n;
        bit seen;
        bit busy_ok;
        bcd_in = bcd;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk({nm, "_busy_e0"}, 64'(busy), 64'(1));
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", nm, n);
        end else begin
            chk({nm, "_latency"}, 64'(n), 64'(lat));
            chk({nm, "_busy_held"}, 64'(busy_ok), 64'(1));
            if (chk_bin) chk({nm, "_bin"}, 64'(bin_out), 64'(eb));
            chk({nm, "_err"}, 64'(err), 64'(ee));
            chk({nm, "_busy_at_done"}, 64'(busy), 64'(0));
        end
        tick();
        chk({nm, "_done_pulse"}, 64'(done), 64'(0));
        if (chk_bin) chk({nm, "_bin_hold"}, 64'(bin_out), 64'(eb));
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  s2;
        logic [43:0] rb;

        vecs[0] = '{44'h00000000000, 37'd0};
        vecs[1] = '{44'h99999999999, 37'h174876E7FF};
        vecs[2] = '{44'h00000012345, 37'h3039};
        vecs[3] = '{44'h00000000255, 37'd255};
        vecs[4] = '{44'h00000000001, 37'd1};
        vecs[5] = '{44'h00000001000, 37'd1000};
        vecs[6] = '{44'h10000000000, 37'd10000000000};
        vecs[7] = '{44'h00000000009, 37'd9};
        vecs[8] = '{44'h90000000000, 37'd90000000000};
        vecs[9] = '{44'h00000000010, 37'd10};

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err",  64'(err),  64'(0));
        chk("rst_bin",  64'(bin_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++)
            run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, 1'b0, BIN_W, 1'b1);

        // Reset in the middle of a conversion
        bcd_in = 44'h99999999999;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_err",  64'(err),  64'(0));
        chk("midrst_bin",  64'(bin_out), 64'(0));
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (45) begin
            tick();
            if (done) seen = 1;
        end
        chk("midrst_no_done", 64'(seen), 64'(0));
        run_conv("after_rst", 44'h00000012345, 37'h3039, 1'b0, BIN_W, 1'b1);

        // Start pulses while busy are ignored
        bcd_in = 44'h00000000255;
        start  = 1'b1;
        tick();
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            if (n == 4 || n == 19) begin
                start  = 1'b1;
                bcd_in = 44'h00000000999;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("hs_seen", 64'(seen), 64'(1));
        chk("hs_latency", 64'(n), 64'(BIN_W));
        chk("hs_bin", 64'(bin_out), 64'(255));
        chk("hs_busy", 64'(busy), 64'(0));
        s2 = 0;
        repeat (45) begin
            tick();
            if (done || busy) s2 = 1;
        end
        chk("hs_no_extra", 64'(s2), 64'(0));

        // Back-to-back with start held high
        bcd_in = 44'h00000000001;
        start  = 1'b1;
        tick();
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (done) seen = 1;
        end
        chk("b2b1_latency", 64'(n), 64'(BIN_W));
        chk("b2b1_bin", 64'(bin_out), 64'(1));
        bcd_in = 44'h00000001000;
        tick();
        start = 1'b0;
        chk("b2b2_busy", 64'(busy), 64'(1));
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (done) seen = 1;
        end
        chk("b2b2_latency", 64'(n), 64'(BIN_W));
        chk("b2b2_bin", 64'(bin_out), 64'(1000));
        tick();

        // Invalid digit
`ifdef BCD2BIN_CHECK_EN
        run_conv("inv", 44'h0000000000A, 37'd0, 1'b1, 1, 1'b1);
        run_conv("inv_clear", 44'h00000000007, 37'd7, 1'b0, BIN_W, 1'b1);
`else
        run_conv("inv", 44'h0000000000A, 37'd0, 1'b0, BIN_W, 1'b0);
`endif

        // Random valid words against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            rb = rand_bcd();
            run_conv($sformatf("rnd%0d", i), rb, model_bin(rb), 1'b0, BIN_W, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
